// File: rtl/seg_scan_ctrl_pkg.sv
// Package seg_pkg: types and constants shared by the 7-segment scan controller.
//   scan_state_t : scan FSM states
//   SEG_BLANK    : all segments off (active-low)
//   AN_OFF       : all digit enables off (active-low), sliced to N_DIGITS by users
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GUARD,
    SHOW
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam int         MAX_DIGITS = 8;
  localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

endpackage

// File: rtl/seg_scan_ctrl_hexdigit.sv
// hexdigit: nibble to 7-segment decoder, segments {g..a}, active-low.
// Only 0-9 light up; A-F render blank.
// Ports:
//   nib : input  [3:0] value to display
//   seg : output [6:0] segment pattern, active-low
module hexdigit
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an N-digit common-anode
// 7-segment display with a single shared hexdigit decoder.
// New words arrive via valid/ready into a pending buffer and are committed to
// the display register only at frame start (digit 0 entering its dwell).
// Optional macro SEG_LZ_BLANK_EN: blank leading zeros (digit 0 always shown).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : scan enable (0 = dark, scan restarts from digit 0)
//   load_valid  : load_data valid
//   load_ready  : pending buffer free
//   load_data   : nibble i drives digit i (digit 0 rightmost)
//   seg_out     : segments {g..a}, active-low, registered
//   an_out      : digit enables, active-low, registered, at most one low
//   frame_sync  : one-cycle pulse when digit 0 begins its dwell
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int TICK_DIV  = 50000,
  parameter int DWELL     = 1,
  parameter int GUARD_CYC = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*N_DIGITS-1:0] load_data,
  output logic [6:0]            seg_out,
  output logic [N_DIGITS-1:0]   an_out,
  output logic                  frame_sync
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int P_W   = $clog2(TICK_DIV);
  localparam int D_W   = $clog2(DWELL + 1);
  localparam int G_W   = $clog2(GUARD_CYC + 1);

  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [P_W-1:0]      P_LAST     = P_W'(TICK_DIV - 1);
  localparam logic [D_W-1:0]      D_LAST     = D_W'(DWELL - 1);
  localparam logic [G_W-1:0]      G_LAST     = G_W'(GUARD_CYC - 1);
  localparam logic [N_DIGITS-1:0] AN_ALL_OFF = AN_OFF[N_DIGITS-1:0];

  scan_state_t           state, state_nx;
  logic [IDX_W-1:0]      idx, idx_nx;
  logic [P_W-1:0]        presc, presc_nx;
  logic [D_W-1:0]        dcnt, dcnt_nx;
  logic [G_W-1:0]        gcnt, gcnt_nx;
  logic [4*N_DIGITS-1:0] display, display_nx;
  logic [4*N_DIGITS-1:0] pending;
  logic                  pending_full;
  logic                  commit, accept;
  logic [3:0]            nib;
  logic [6:0]            dec_seg, seg_nx;
  logic [N_DIGITS-1:0]   an_nx;
  logic                  blank, lit;

  assign load_ready = ~pending_full;
  assign accept     = load_valid & ~pending_full;
  // Only a full buffer replaces the display; an empty one leaves it as is.
  assign display_nx = (commit && pending_full) ? pending : display;

  // Next-state: prescaler, dwell and guard counters, digit index.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    presc_nx = presc;
    dcnt_nx  = dcnt;
    gcnt_nx  = gcnt;
    commit   = 1'b0;
    if (!en) begin
      state_nx = IDLE;
      idx_nx   = '0;
      presc_nx = '0;
      dcnt_nx  = '0;
      gcnt_nx  = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = GUARD;
          gcnt_nx  = '0;
        end
        GUARD: begin
          if (gcnt == G_LAST) begin
            state_nx = SHOW;
            presc_nx = '0;
            dcnt_nx  = '0;
            commit   = (idx == '0);
          end else begin
            gcnt_nx = gcnt + 1'b1;
          end
        end
        SHOW: begin
          if (presc == P_LAST) begin
            presc_nx = '0;
            if (dcnt == D_LAST) begin
              state_nx = GUARD;
              gcnt_nx  = '0;
              idx_nx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
              dcnt_nx = dcnt + 1'b1;
            end
          end else begin
            presc_nx = presc + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Outputs are decoded from next-state values so the registered seg/an
  // track the state register exactly.
  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_nx == IDX_W'(i)) nib = display_nx[4*i +: 4];
    end
  end

  hexdigit u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  always_comb begin
    blank = 1'b0;
`ifdef SEG_LZ_BLANK_EN
    // Blank when this digit and every more-significant digit are zero.
    blank = (idx_nx != '0);
    for (int i = 0; i < N_DIGITS; i++) begin
      if ((IDX_W'(i) >= idx_nx) && (display_nx[4*i +: 4] != 4'h0)) blank = 1'b0;
    end
`endif
    lit    = (state_nx == SHOW) && !blank;
    seg_nx = lit ? dec_seg : SEG_BLANK;
    an_nx  = AN_ALL_OFF;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (lit && (idx_nx == IDX_W'(i))) an_nx[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      presc        <= '0;
      dcnt         <= '0;
      gcnt         <= '0;
      display      <= '0;
      pending_full <= 1'b0;
      seg_out      <= SEG_BLANK;
      an_out       <= AN_ALL_OFF;
      frame_sync   <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      presc      <= presc_nx;
      dcnt       <= dcnt_nx;
      gcnt       <= gcnt_nx;
      display    <= display_nx;
      seg_out    <= seg_nx;
      an_out     <= an_nx;
      frame_sync <= commit;
      // accept needs an empty buffer, so it never collides with a commit.
      if (accept)                      pending_full <= 1'b1;
      else if (commit && pending_full) pending_full <= 1'b0;
    end
  end

  // Pending word holds data only; validity lives in pending_full.
  always_ff @(posedge clk) begin
    if (accept) pending <= load_data;
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int GC = 2;

  logic        clk = 1'b0;
  logic        rst_n, en, load_valid, load_ready, frame_sync;
  logic [15:0] load_data;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;

  seg_scan_ctrl #(.N_DIGITS(N), .TICK_DIV(TD), .DWELL(1), .GUARD_CYC(GC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_sync (frame_sync)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] idx;
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  logic [15:0] model_disp, model_pend, mid_word, hold_word;
  logic        model_pend_full, hold_active, do_mid, do_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Push the digits a frame of model_disp is expected to light, in scan order.
  task automatic push_frame();
    exp_t        e;
    logic        blanked;
    logic [3:0]  mask;
    for (int i = 0; i < N; i++) begin
      blanked = 1'b0;
`ifdef SEG_LZ_BLANK_EN
      blanked = (i > 0);
      for (int j = i; j < N; j++) if (model_disp[4*j +: 4] != 4'h0) blanked = 1'b0;
`endif
      if (!blanked) begin
        mask   = 4'b0001 << i;
        e.idx  = 3'(i);
        e.an   = ~mask;
        e.seg  = hex7(model_disp[4*i +: 4]);
        sbq.push_back(e);
      end
    end
  endtask

  // Check one frame starting at (or waiting for) frame_sync; returns at the
  // first cycle of the following frame.
  task automatic check_frame();
    exp_t e;
    int   n, lit, gap, cnt, next_idx;
    logic hold_now;
    n = 0;
    while (frame_sync !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("frame_sync_seen", 32'(frame_sync), 1);
    if (model_pend_full) begin
      model_disp      = model_pend;
      model_pend_full = 1'b0;
    end
    hold_now = hold_active;
    if (hold_now) chk("ready_on_sync_cycle", 32'(load_ready), 1);
    push_frame();
    cnt = sbq.size();
    for (int k = 0; k < cnt; k++) begin
      e        = sbq.pop_front();
      next_idx = (sbq.size() > 0) ? int'(sbq[0].idx) : N;
      chk($sformatf("an_d%0d", e.idx), 32'(an_out), 32'(e.an));
      chk($sformatf("seg_d%0d", e.idx), 32'(seg_out), 32'(e.seg));
      lit = 0;
      while (an_out === e.an && lit < 40) begin
        if (do_mid && e.idx == 1 && lit == 0) begin
          chk("mid_ready_before", 32'(load_ready), 1);
          load_valid = 1'b1; load_data = mid_word;
          model_pend = mid_word; model_pend_full = 1'b1;
        end
        if (do_mid && e.idx == 1 && lit == 1) begin
          chk("mid_ready_after", 32'(load_ready), 0);
          load_valid = 1'b0;
        end
        if (do_hold && e.idx == 3 && lit == 0) begin
          chk("hold_ready_low", 32'(load_ready), 0);
          load_valid = 1'b1; load_data = hold_word; hold_active = 1'b1;
        end
        if (hold_now && e.idx == 0 && lit == 1) begin
          chk("hold_accepted", 32'(load_ready), 0);
          load_valid = 1'b0;
          model_pend = hold_word; model_pend_full = 1'b1; hold_active = 1'b0;
        end
        if (lit > 0) chk("seg_stable", 32'(seg_out), 32'(e.seg));
        @(negedge clk); lit++;
      end
      chk("lit_cycles", 32'(lit), 32'(TD));
      gap = 0;
      while (an_out === 4'hF && gap < 60) begin @(negedge clk); gap++; end
      chk("gap_cycles", 32'(gap), 32'(GC + (TD + GC) * (next_idx - int'(e.idx) - 1)));
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; en = 1'b0; load_valid = 1'b0; load_data = '0;
    model_disp = '0; model_pend = '0; model_pend_full = 1'b0;
    hold_active = 1'b0; do_mid = 1'b0; do_hold = 1'b0;
    mid_word = '0; hold_word = '0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an_out), 32'hF);
    chk("rst_seg", 32'(seg_out), 32'h7F);
    chk("rst_ready", 32'(load_ready), 1);
    chk("rst_fsync", 32'(frame_sync), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_an", 32'(an_out), 32'hF);

    // Load 1234 while idle, then enable.
    load_valid = 1'b1; load_data = 16'h1234;
    @(negedge clk);
    load_valid = 1'b0;
    chk("idle_load_ready", 32'(load_ready), 0);
    model_pend = 16'h1234; model_pend_full = 1'b1;
    en = 1'b1;
    check_frame();

    // Mid-frame load of 5678, plus load_valid held across the next commit.
    do_mid = 1'b1; mid_word = 16'h5678;
    do_hold = 1'b1; hold_word = 16'h9012;
    check_frame();
    do_mid = 1'b0; do_hold = 1'b0;
    check_frame();
    check_frame();

    // Drop en while digit 2 is lit.
    n = 0;
    while (an_out !== 4'hB && n < 40) begin @(negedge clk); n++; end
    chk("reach_digit2", 32'(an_out), 32'hB);
    en = 1'b0;
    @(negedge clk);
    chk("en_low_an", 32'(an_out), 32'hF);
    chk("en_low_seg", 32'(seg_out), 32'h7F);
    @(negedge clk);
    en = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (frame_sync !== 1'b1 && n < 20);
    chk("restart_latency", 32'(n), 3);
    chk("restart_digit0", 32'(an_out), 32'hE);
    check_frame();

    // Reset mid-SHOW with a word pending.
    load_valid = 1'b1; load_data = 16'h4321;
    @(negedge clk);
    load_valid = 1'b0;
    chk("pre_rst_ready", 32'(load_ready), 0);
    rst_n = 1'b0; en = 1'b0;
    #1;
    chk("async_rst_an", 32'(an_out), 32'hF);
    chk("async_rst_seg", 32'(seg_out), 32'h7F);
    chk("async_rst_fsync", 32'(frame_sync), 0);
    chk("async_rst_ready", 32'(load_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_disp = '0; model_pend_full = 1'b0; hold_active = 1'b0;
    @(negedge clk);
    chk("rel_ready", 32'(load_ready), 1);

    // Leading-zero word.
    load_valid = 1'b1; load_data = 16'h0070;
    @(negedge clk);
    load_valid = 1'b0;
    model_pend = 16'h0070; model_pend_full = 1'b1;
    en = 1'b1;
    check_frame();
    chk("queue_drained", 32'(sbq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
